// File: rtl/branch_update_queue.sv
// FIFO of resolved-branch updates feeding the predictor one per cycle; enqueue-to-new_entry latency 1, in_ready = ~full.
// Head outputs come from storage only. `BUQ_COALESCE_EN merges a same-PC update into the youngest entry.
module branch_update_queue #(
    parameter int PC_BITS   = 32,
    parameter int DEPTH     = 8,
    parameter int STAT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_BITS-1:0]       in_pc_orig,
    input  logic [PC_BITS-1:0]       in_target_pc,
    input  logic                     in_is_taken,
    input  logic                     drain_hold,
    output logic                     new_entry,
    output logic [PC_BITS-1:0]       pc_orig,
    output logic [PC_BITS-1:0]       target_pc,
    output logic                     is_taken,
    output logic [$clog2(DEPTH):0]   count,
    output logic [STAT_BITS-1:0]     coalesce_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_BITS-1:0] pc_mem  [DEPTH];
    logic [PC_BITS-1:0] tgt_mem [DEPTH];
    logic [DEPTH-1:0]   tk_mem;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
    logic             empty;
    logic             full;
    logic             pop;
    logic             accept;
    logic             coalesce;
    logic             alloc;

    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_W'(DEPTH));
    assign in_ready  = ~full;
    assign new_entry = ~empty & ~drain_hold;
    assign pop       = new_entry;
    assign accept    = in_valid & in_ready;
    assign alloc     = accept & ~coalesce;
    assign count     = cnt;

    assign pc_orig   = empty ? '0   : pc_mem[head];
    assign target_pc = empty ? '0   : tgt_mem[head];
    assign is_taken  = empty ? 1'b0 : tk_mem[head];

`ifdef BUQ_COALESCE_EN
    logic [PTR_W-1:0] youngest;
    assign youngest = tail - PTR_W'(1);

    // A lone entry that leaves this cycle cannot absorb the update; it must allocate behind it.
    assign coalesce = accept & ~empty & (pc_mem[youngest] == in_pc_orig)
                    & ~((cnt == CNT_W'(1)) & pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coalesce_cnt <= '0;
        end else if (coalesce && (coalesce_cnt != '1)) begin
            coalesce_cnt <= coalesce_cnt + STAT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            pc_mem[tail]  <= in_pc_orig;
            tgt_mem[tail] <= in_target_pc;
            tk_mem[tail]  <= in_is_taken;
        end else if (coalesce) begin
            tgt_mem[youngest] <= in_target_pc;
            tk_mem[youngest]  <= in_is_taken;
        end
    end
`else
    assign coalesce     = 1'b0;
    assign coalesce_cnt = '0;

    always_ff @(posedge clk) begin
        if (alloc) begin
            pc_mem[tail]  <= in_pc_orig;
            tgt_mem[tail] <= in_target_pc;
            tk_mem[tail]  <= in_is_taken;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (alloc) tail <= tail + PTR_W'(1);
            if (pop)   head <= head + PTR_W'(1);
            case ({alloc, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_branch_update_queue;

    localparam int PCB = 32;
    localparam int D   = 8;
    localparam int SB  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_is_taken = 1'b0;
    logic           drain_hold = 1'b0;
    logic [PCB-1:0] in_pc_orig = '0;
    logic [PCB-1:0] in_target_pc = '0;

    logic           in_ready;
    logic           new_entry;
    logic [PCB-1:0] pc_orig;
    logic [PCB-1:0] target_pc;
    logic           is_taken;
    logic [3:0]     count;
    logic [SB-1:0]  coalesce_cnt;

    branch_update_queue #(.PC_BITS(PCB), .DEPTH(D), .STAT_BITS(SB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_orig(in_pc_orig), .in_target_pc(in_target_pc), .in_is_taken(in_is_taken),
        .drain_hold(drain_hold), .new_entry(new_entry),
        .pc_orig(pc_orig), .target_pc(target_pc), .is_taken(is_taken),
        .count(count), .coalesce_cnt(coalesce_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted updates
    typedef struct {
        logic [PCB-1:0] pc;
        logic [PCB-1:0] tgt;
        logic           tk;
    } ent_t;

    ent_t q[$];
    int   m_ccnt = 0;
    bit   m_pop, m_acc, m_coal;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ccnt = 0;
        end else begin
            m_pop  = (q.size() != 0) && !drain_hold;
            m_acc  = in_valid && (q.size() < D);
            m_coal = 1'b0;
`ifdef BUQ_COALESCE_EN
            m_coal = m_acc && (q.size() != 0) && (q[q.size()-1].pc == in_pc_orig)
                     && !(q.size() == 1 && m_pop);
`endif
            if (m_coal) begin
                q[q.size()-1].tgt = in_target_pc;
                q[q.size()-1].tk  = in_is_taken;
                if (m_ccnt < (1 << SB) - 1) m_ccnt++;
            end
            if (m_pop) void'(q.pop_front());
            if (m_acc && !m_coal) q.push_back('{in_pc_orig, in_target_pc, in_is_taken});
        end
    end

    // Compare process: outputs are stable mid-cycle
    always @(negedge clk) begin
        logic [PCB-1:0] e_pc, e_tgt;
        logic           e_tk;
        e_pc  = (q.size() != 0) ? q[0].pc  : '0;
        e_tgt = (q.size() != 0) ? q[0].tgt : '0;
        e_tk  = (q.size() != 0) ? q[0].tk  : 1'b0;
        chk("m_count",     count,        64'(q.size()));
        chk("m_in_ready",  in_ready,     64'(q.size() < D));
        chk("m_new_entry", new_entry,    64'((q.size() != 0) && !drain_hold));
        chk("m_pc_orig",   pc_orig,      64'(e_pc));
        chk("m_target_pc", target_pc,    64'(e_tgt));
        chk("m_is_taken",  is_taken,     64'(e_tk));
        chk("m_coal_cnt",  coalesce_cnt, 64'(m_ccnt));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PCB-1:0] pc, input logic [PCB-1:0] tgt,
                         input logic tk);
        in_valid     = v;
        in_pc_orig   = pc;
        in_target_pc = tgt;
        in_is_taken  = tk;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        drain_hold = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_new_entry", new_entry, 0);
        chk("rst_pc_orig", pc_orig, 0);
        chk("rst_coal_cnt", coalesce_cnt, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: single push, visible one cycle later, then drained
        drive(1, 32'h100, 32'h200, 1);
        #1 chk("t1_no_bypass", new_entry, 0);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("t1_new_entry", new_entry, 1);
        chk("t1_pc", pc_orig, 32'h100);
        chk("t1_tgt", target_pc, 32'h200);
        chk("t1_tk", is_taken, 1);
        cyc();
        chk("t1_count_after", count, 0);
        chk("t1_new_after", new_entry, 0);

        // 2: fill under hold, 9th ignored, drain in order
        drain_hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), 1'(i));
            cyc();
        end
        drive(1, 32'h9999, 32'h9999, 1);
        #1;
        chk("t2_count_full", count, 8);
        chk("t2_in_ready", in_ready, 0);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("t2_count_9th", count, 8);
        drain_hold = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_pop_vld", new_entry, 1);
            chk("t2_pop_pc", pc_orig, 32'h1000 + 32'(i * 4));
            cyc();
        end
        chk("t2_empty", count, 0);

        // 3: steady push+pop at count 6 with pointer wrap
        drain_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h3000 + 32'(i * 4), 32'h4000 + 32'(i), 1'(i));
            cyc();
        end
        drain_hold = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(1, 32'h3000 + 32'((6 + k) * 4), 32'h4000 + 32'(6 + k), 1'(k));
            cyc();
            chk("t3_count", count, 6);
            chk("t3_head", pc_orig, 32'h3000 + 32'((k + 1) * 4));
        end
        in_valid = 1'b0;
        repeat (7) cyc();
        chk("t3_drained", count, 0);

        // 4: back-to-back same PC under hold
        do_reset();
        drain_hold = 1'b1;
        drive(1, 32'h100, 32'h140, 0);
        cyc();
        drive(1, 32'h100, 32'h180, 1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("t4_pc", pc_orig, 32'h100);
`ifdef BUQ_COALESCE_EN
        chk("t4_count", count, 1);
        chk("t4_coal", coalesce_cnt, 1);
        chk("t4_tgt", target_pc, 32'h180);
        chk("t4_tk", is_taken, 1);
`else
        chk("t4_count", count, 2);
        chk("t4_coal", coalesce_cnt, 0);
        chk("t4_tgt", target_pc, 32'h140);
        chk("t4_tk", is_taken, 0);
`endif

        // 5: same PC as a head that is popping allocates
        do_reset();
        drain_hold = 1'b1;
        drive(1, 32'h500, 32'h600, 0);
        cyc();
        drain_hold = 1'b0;
        drive(1, 32'h500, 32'h700, 1);
        #1 chk("t5_pop", new_entry, 1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("t5_count", count, 1);
        chk("t5_coal", coalesce_cnt, 0);
        chk("t5_tgt", target_pc, 32'h700);
        chk("t5_tk", is_taken, 1);
        cyc();

        // 6: async reset mid-drain
        do_reset();
        drain_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h6000 + 32'(i * 4), 32'h7000, 0);
            cyc();
        end
        in_valid = 1'b0;
        drain_hold = 1'b0;
        cyc();
        cyc();
        chk("t6_count_mid", count, 3);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_new_entry", new_entry, 0);
        chk("t6_count", count, 0);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_pc", pc_orig, 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_no_stale", new_entry, 0);
        end

        // Randomized traffic with phase-varying hold pressure and rare async resets
        begin
            int hold_pct;
            hold_pct = 30;
            for (int c = 0; c < 3000; c++) begin
                if (c % 100 == 0) hold_pct = $urandom_range(0, 90);
                if (!rst_n) rst_n = 1'b1;
                else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
                drain_hold = ($urandom_range(0, 99) < hold_pct);
                drive($urandom_range(0, 9) < 6, 32'h100 + 32'(4 * $urandom_range(0, 3)),
                      $urandom, 1'($urandom));
                cyc();
            end
            rst_n = 1'b1;
            in_valid = 1'b0;
            drain_hold = 1'b0;
            repeat (10) cyc();
            chk("final_empty", count, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
